// File: rtl/rv_data_mem.sv
// Byte-addressable data memory for the RV32I load/store unit.
// One request per cycle is always accepted. The response (extended load data
// or fault flag) is registered and appears for one cycle after the sampling edge.
// Stores to word MMIO_IDX are mirrored into a reset-clearable output register.
module rv_data_mem #(
  parameter int ADDR_W   = 10,
  parameter int MMIO_IDX = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mmio_reg,
  output logic [7:0]  fault_cnt
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] MMIO_W = ADDR_W'(MMIO_IDX);

  logic [31:0]       mem_q [DEPTH];
  logic              rsp_valid_q;
  logic [31:0]       rsp_rdata_q;
  logic              rsp_fault_q;
  logic [31:0]       mmio_q;
  logic [7:0]        fault_cnt_q;

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              fault_d;
  logic [31:0]       load_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_al;
  logic [31:0]       merged_d;
  logic              store_ok;
  logic              load_ok;

  assign idx      = req_addr[ADDR_W+1:2];
  assign lane     = req_addr[1:0];
  assign rd_word  = mem_q[idx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign store_ok = req_valid &  req_we & ~fault_d;
  assign load_ok  = req_valid & ~req_we & ~fault_d;

  // Fault detection: reserved size, misalignment, or address beyond the array
  always_comb begin
    fault_d = 1'b0;
    case (req_size)
      2'b00:   fault_d = 1'b0;
      2'b01:   fault_d = lane[0];
      2'b10:   fault_d = (lane != 2'b00);
      default: fault_d = 1'b1;
    endcase
    if (req_addr[31:ADDR_W+2] != '0) fault_d = 1'b1;
  end

  // Load lane selection and sign/zero extension; words ignore req_unsigned
  always_comb begin
    case (req_size)
      2'b00:   load_d = req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_d = req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_d = rd_word;
    endcase
  end

  // Store byte-enables and lane-replicated write data merged over the old word
  always_comb begin
    case (req_size)
      2'b00: begin
        be_d     = 4'b0001 << lane;
        wdata_al = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d     = 4'b0011 << lane;
        wdata_al = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d     = 4'b1111;
        wdata_al = req_wdata;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      merged_d[8*b +: 8] = be_d[b] ? wdata_al[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  // Memory array write; not cleared by reset, requests during reset are dropped
  always_ff @(posedge clk) begin
    if (rst_n && store_ok) mem_q[idx] <= merged_d;
  end

  // Registered response, MMIO shadow and saturating fault counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      mmio_q      <= '0;
      fault_cnt_q <= '0;
    end else begin
      rsp_valid_q <= req_valid;
      rsp_fault_q <= req_valid & fault_d;
      rsp_rdata_q <= load_ok ? load_d : '0;
      if (store_ok && idx == MMIO_W) mmio_q <= merged_d;
      if (req_valid && fault_d && fault_cnt_q != 8'hFF) fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign mmio_reg  = mmio_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_rv_data_mem.sv
// Self-checking bench for rv_data_mem: a byte-array reference model produces
// expected responses into a scoreboard queue as each request is driven; each
// test pops and compares once the response is visible after the edge.
module tb_rv_data_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;
  logic [31:0] mmio_reg;
  logic [7:0]  fault_cnt;

  always #5 clk = ~clk;

  rv_data_mem #(.ADDR_W(10), .MMIO_IDX(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_fault(rsp_fault), .mmio_reg(mmio_reg), .fault_cnt(fault_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [31:0] mmio;
    logic [7:0]  fcnt;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] c_rd;
    logic        chk_mm;
    logic [31:0] c_mm;
  } op_t;

  exp_t        sb[$];
  logic [7:0]  mdl [4096];
  logic [31:0] m_mmio;
  logic [7:0]  m_fcnt;
  int          vectors;
  int          miscompares;

  function automatic op_t mk(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic chk_rd = 1'b0, input logic [31:0] c_rd = '0,
                             input logic chk_mm = 1'b0, input logic [31:0] c_mm = '0);
    op_t o;
    o.we = we; o.size = size; o.uns = uns; o.addr = addr; o.wdata = wdata;
    o.chk_rd = chk_rd; o.c_rd = c_rd; o.chk_mm = chk_mm; o.c_mm = c_mm;
    return o;
  endfunction

  function automatic logic mfault(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'd0) || (addr[31:12] != 20'd0);
  endfunction

  // Drive one request, predict its response into the scoreboard, step one edge.
  task automatic req(input op_t o);
    exp_t        e;
    logic [31:0] v;
    logic [11:0] a;
    int          n;
    a = o.addr[11:0];
    n = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
    e.rdata = '0;
    e.fault = mfault(o.size, o.addr);
    if (!e.fault) begin
      if (o.we) begin
        for (int i = 0; i < n; i++) mdl[a + 12'(i)] = o.wdata[8*i +: 8];
        if (a[11:2] == 10'd32)
          m_mmio = {mdl[{a[11:2], 2'd3}], mdl[{a[11:2], 2'd2}], mdl[{a[11:2], 2'd1}], mdl[{a[11:2], 2'd0}]};
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a + 12'(i)];
        if (!o.uns && n < 4 && v[8*n-1])
          for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        e.rdata = v;
      end
    end else if (m_fcnt != 8'hFF) begin
      m_fcnt = m_fcnt + 8'd1;
    end
    e.mmio = m_mmio;
    e.fcnt = m_fcnt;
    sb.push_back(e);
    req_valid    = 1'b1;
    req_we       = o.we;
    req_size     = o.size;
    req_unsigned = o.uns;
    req_addr     = o.addr;
    req_wdata    = o.wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op_t  o;
    exp_t e;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_fault !== 1'b0 ||
        mmio_reg !== 32'h0 || fault_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_init: got v=%b d=%h f=%b mmio=%h cnt=%0d, want all zero",
               rsp_valid, rsp_rdata, rsp_fault, mmio_reg, fault_cnt);
    end
    rst_n = 1'b1;
    req(mk(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF));
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_fault !== e.fault ||
        mmio_reg !== e.mmio || fault_cnt !== e.fcnt) begin
      miscompares++;
      $display("FAIL reset_store: got v=%b d=%h f=%b mmio=%h cnt=%0d, want d=%h f=%b mmio=%h cnt=%0d",
               rsp_valid, rsp_rdata, rsp_fault, mmio_reg, fault_cnt, e.rdata, e.fault, e.mmio, e.fcnt);
    end
    // a store presented during reset must be discarded
    rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h10; req_wdata = 32'h11111111;
    @(posedge clk);
    #1;
    m_mmio = '0; m_fcnt = '0;
    vectors++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_fault !== 1'b0 ||
        mmio_reg !== 32'h0 || fault_cnt !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_clear: got v=%b d=%h f=%b mmio=%h cnt=%0d, want all zero",
               rsp_valid, rsp_rdata, rsp_fault, mmio_reg, fault_cnt);
    end
    rst_n = 1'b1;
    req_valid = 1'b0;
    o = mk(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF);
    req(o);
    e = sb.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_rdata !== o.c_rd ||
        rsp_fault !== e.fault || fault_cnt !== e.fcnt) begin
      miscompares++;
      $display("FAIL reset_retain: got v=%b d=%h f=%b cnt=%0d, want d=%h f=%b cnt=%0d",
               rsp_valid, rsp_rdata, rsp_fault, fault_cnt, o.c_rd, e.fault, e.fcnt);
    end
    idle();
  endtask

  // Runs an op list back-to-back, comparing each response against the model
  // and, where flagged, against fixed expected values.
  task automatic test_ops(input string name, input op_t ops[$]);
    exp_t e;
    foreach (ops[k]) begin
      req(ops[k]);
      e = sb.pop_front();
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_fault !== e.fault ||
          mmio_reg !== e.mmio || fault_cnt !== e.fcnt ||
          (ops[k].chk_rd && rsp_rdata !== ops[k].c_rd) ||
          (ops[k].chk_mm && mmio_reg !== ops[k].c_mm)) begin
        miscompares++;
        $display("FAIL %s[%0d]: got v=%b d=%h f=%b mmio=%h cnt=%0d, want d=%h f=%b mmio=%h cnt=%0d",
                 name, k, rsp_valid, rsp_rdata, rsp_fault, mmio_reg, fault_cnt,
                 ops[k].chk_rd ? ops[k].c_rd : e.rdata, e.fault,
                 ops[k].chk_mm ? ops[k].c_mm : e.mmio, e.fcnt);
      end
    end
  endtask

  task automatic test_byte_lanes();
    op_t ops[$];
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h0));
    ops.push_back(mk(1'b1, 2'd0, 1'b0, 32'h23, 32'h80));
    ops.push_back(mk(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 1'b1, 32'hFFFFFF80));
    ops.push_back(mk(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, 1'b1, 32'h00000080));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h80000000));
    test_ops("byte_lanes", ops);
    idle();
  endtask

  task automatic test_halfword();
    op_t ops[$];
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h30, 32'h0));
    ops.push_back(mk(1'b1, 2'd1, 1'b0, 32'h32, 32'h8001));
    ops.push_back(mk(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b1, 32'hFFFF8001));
    ops.push_back(mk(1'b0, 2'd1, 1'b1, 32'h32, 32'h0, 1'b1, 32'h00008001));
    ops.push_back(mk(1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 1'b1, 32'h0));
    test_ops("halfword", ops);
    vectors++;
    if (fault_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL half_fault_cnt: got %0d, want 1", fault_cnt);
    end
    idle();
  endtask

  task automatic test_faults();
    op_t ops[$];
    op_t sat[$];
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h22, 32'h0));
    ops.push_back(mk(1'b1, 2'd3, 1'b0, 32'h20, 32'h0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0));
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h1020, 32'h0));
    ops.push_back(mk(1'b1, 2'd1, 1'b0, 32'h21, 32'h0));
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h22, 32'h0));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'hCAFEF00D));
    test_ops("faults", ops);
    for (int i = 0; i < 300; i++)
      sat.push_back(mk(i[0], 2'd3, 1'b0, 32'h40, 32'hFFFFFFFF));
    test_ops("fault_sat", sat);
    vectors++;
    if (fault_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL fault_saturate: got %0d, want 255", fault_cnt);
    end
    idle();
  endtask

  task automatic test_mmio();
    op_t ops[$];
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h80, 32'h12345678, 1'b0, 32'h0, 1'b1, 32'h12345678));
    ops.push_back(mk(1'b1, 2'd0, 1'b0, 32'h81, 32'hAA, 1'b0, 32'h0, 1'b1, 32'h1234AA78));
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h84, 32'h99999999, 1'b0, 32'h0, 1'b1, 32'h1234AA78));
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h1080, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234AA78));
    test_ops("mmio", ops);
    idle();
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h20, 32'h5A5A1234));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h5A5A1234));
    ops.push_back(mk(1'b1, 2'd0, 1'b0, 32'h21, 32'h77));
    ops.push_back(mk(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 32'h5A5A7734));
    ops.push_back(mk(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1, 32'h00005A5A));
    test_ops("back_to_back", ops);
    idle();
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rsp_drop: got rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_random();
    op_t ops[$];
    for (int w = 0; w < 16; w++)
      ops.push_back(mk(1'b1, 2'd2, 1'b0, 32'h100 + 32'(4*w), $urandom));
    for (int i = 0; i < 200; i++)
      ops.push_back(mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       32'h100 + 32'($urandom_range(0, 63)), $urandom));
    test_ops("random", ops);
    idle();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    m_mmio = '0; m_fcnt = '0;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_byte_lanes();
    test_halfword();
    test_mmio();
    test_back_to_back();
    test_faults();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_data_mem.md
Name: rv_data_mem

Overview:
- Parametrised byte-addressable data memory for the RV32I single-cycle core's load/store unit.
- Replaces the fixed 4 KB word RAM with:
  - a valid/response handshake;
  - RV32I load extension (LB/LH/LW/LBU/LHU);
  - misalignment, range and size fault detection;
  - a reset-clearable memory-mapped output register.
- Sits between the execute stage and the writeback mux.

Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words of 32 bits.
- MMIO_IDX, 32, word index whose stores are mirrored to mmio_reg; must be < 2**ADDR_W.

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present this cycle; one request per cycle, always accepted
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  response for the request accepted on the previous edge
- rsp_rdata  out  32  extended load data; 0 for stores and faults
- rsp_fault  out  1  qualifies rsp_valid; request faulted
- mmio_reg  out  32  shadow of word MMIO_IDX
- fault_cnt  out  8  saturating count of faulted requests

Behaviour:
- Reset (rst_n=0 at an edge):
  - rsp_valid, rsp_rdata, rsp_fault, mmio_reg and fault_cnt go to 0.
  - Any request presented in that cycle is discarded.
  - Memory array is not cleared; it is zero-initialised at time 0 only.
- Latency: a request sampled at edge N yields rsp_valid=1 after edge N, for exactly one cycle. With req_valid=0 at edge N, rsp_valid=0 after edge N. Back-to-back requests give back-to-back responses.
- Word index = req_addr[ADDR_W+1:2]; lane = req_addr[1:0].
- Fault when any of the following holds (checked combinationally at request time):
  - req_size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - req_addr[31:ADDR_W+2] != 0.
- A faulting request:
  - writes nothing to memory or mmio_reg;
  - returns rsp_fault=1, rsp_rdata=0;
  - increments fault_cnt, which saturates at 255.
- Store:
  - Updates only the addressed byte lanes (byte: one lane; half: lanes 0-1 or 2-3; word: all). Other lanes are unchanged.
  - Returns rsp_fault=0, rsp_rdata=0.
  - If the word index equals MMIO_IDX, mmio_reg receives the same merged word on the same edge.
- Load:
  - Reads the word and selects the lane(s) by addr[1:0].
  - Byte result is bits [7:0] extended to 32; half result is bits [15:0] extended to 32.
  - Extension is sign or zero per req_unsigned. Word loads ignore req_unsigned.
- Store then load to the same word on consecutive cycles: the load returns the updated data.
- There is no same-cycle read/write conflict because there is only one request per cycle.

Test Plan:
- Reset behaviour -> store word 0xDEADBEEF to addr 0x10, then assert rst_n=0 for one cycle -> all outputs 0. Load word 0x10 -> 0xDEADBEEF (memory retained).
- Byte lanes -> store word 0 to 0x20, store byte 0x80 to 0x23, then:
  - LB 0x23 -> 0xFFFFFF80;
  - LBU 0x23 -> 0x00000080;
  - LW 0x20 -> 0x80000000.
- Halfword -> store half 0x8001 to 0x32, then:
  - LH 0x32 -> 0xFFFF8001;
  - LHU -> 0x00008001;
  - LH 0x31 -> rsp_fault=1, rdata 0, fault_cnt=1.
- Faults -> LW 0x22, store size 11, and LW 0x1000 (ADDR_W=10) each give rsp_fault=1 with no memory change; 300 faulting requests -> fault_cnt=255.
- MMIO -> store word 0x12345678 to 0x80 (MMIO_IDX=32) -> mmio_reg=0x12345678 after that edge; then store byte 0xAA to 0x81 -> mmio_reg=0x1234AA78.
- Pipelining -> continuous req_valid with store 0x20 followed by load 0x20 -> load response on the next cycle returns the new value; rsp_valid high every cycle, dropping one cycle after req_valid falls.
